// File: rtl/sr_ff_bank.sv
// WIDTH-bit bank of SR/JK/D/T flip-flops with a sticky SR-conflict flag per bit.
// Optional conflict event counter enabled by defining SR_FF_BANK_CONFLICT_CNT_EN.
module sr_ff_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int unsigned      SR_CONFLICT = 0,
  parameter int unsigned      CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] hold_mask;

  assign both      = s & r;
  assign hold_mask = ~(s | r);

  // Per-bit next state; r is only consulted in SR/JK so an unknown r cannot reach q in D/T.
  always_comb begin
    q_d        = q_q;
    conflict_d = conflict_q;
    hit        = '0;
    if (clr_conflict) begin
      conflict_d = '0;
    end
    if (en) begin
      unique case (mode)
        MODE_SR: begin
          hit = both;
          q_d = (q_q & hold_mask) | (s & ~r);
          if (SR_CONFLICT == 1) begin
            q_d = q_d | both;
          end else if (SR_CONFLICT != 2) begin
            q_d = q_d | (q_q & both);
          end
        end
        MODE_JK: q_d = (q_q & hold_mask) | (s & ~r) | (both & ~q_q);
        MODE_D:  q_d = s;
        MODE_T:  q_d = q_q ^ s;
        default: q_d = q_q;
      endcase
    end
    conflict_d = conflict_d | hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= RESET_VAL;
      conflict_q <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign q_       = ~q_q;
  assign conflict = conflict_q;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One count per conflicting cycle, saturating; a same-edge clear plus event loads 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_conflict) begin
      cnt_d = '0;
    end
    if (|hit) begin
      if (clr_conflict) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Scoreboard bench for sr_ff_bank: three banks (one per SR conflict policy) share stimulus
// and are compared each cycle against a per-bit behavioural model.
module tb_sr_ff_bank;

  localparam int unsigned W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst, en, clr_conflict;
  logic [1:0] mode;
  logic [W-1:0] s, r;

  logic [W-1:0] q0, qn0, c0, q1, qn1, c1, q2, qn2, c2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_CONFLICT(0), .CNT_W(8)) u_p0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_conflict(clr_conflict),
    .q(q0), .q_(qn0), .conflict(c0), .conflict_cnt(cnt0));
  sr_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_CONFLICT(1), .CNT_W(2)) u_p1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_conflict(clr_conflict),
    .q(q1), .q_(qn1), .conflict(c1), .conflict_cnt(cnt1));
  sr_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .SR_CONFLICT(2), .CNT_W(8)) u_p2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .clr_conflict(clr_conflict),
    .q(q2), .q_(qn2), .conflict(c2), .conflict_cnt(cnt2));

  typedef struct {
    logic [W-1:0] q   [3];
    logic [W-1:0] c   [3];
    int           cnt [3];
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_q [3];
  logic [W-1:0] m_c [3];
  int           m_cnt [3];
  int           cnt_max [3] = '{255, 3, 255};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the reference by one edge using the plain flip-flop truth tables.
  task automatic model_edge(input logic i_rst, input logic i_en, input logic [1:0] i_mode,
                            input logic [W-1:0] i_s, input logic [W-1:0] i_r, input logic i_clr);
    for (int k = 0; k < 3; k++) begin
      if (i_rst) begin
        m_q[k] = RV; m_c[k] = '0; m_cnt[k] = 0;
      end else begin
        bit any_conf = 1'b0;
        if (i_clr) begin
          m_c[k] = '0;
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
          m_cnt[k] = 0;
`endif
        end
        if (i_en) begin
          for (int i = 0; i < W; i++) begin
            case (i_mode)
              2'd0: begin
                if (i_s[i] && !i_r[i]) m_q[k][i] = 1'b1;
                else if (!i_s[i] && i_r[i]) m_q[k][i] = 1'b0;
                else if (i_s[i] && i_r[i]) begin
                  m_c[k][i] = 1'b1;
                  any_conf = 1'b1;
                  if (k == 1) m_q[k][i] = 1'b1;
                  else if (k == 2) m_q[k][i] = 1'b0;
                end
              end
              2'd1: begin
                if (i_s[i] && !i_r[i]) m_q[k][i] = 1'b1;
                else if (!i_s[i] && i_r[i]) m_q[k][i] = 1'b0;
                else if (i_s[i] && i_r[i]) m_q[k][i] = !m_q[k][i];
              end
              2'd2: m_q[k][i] = i_s[i];
              default: if (i_s[i]) m_q[k][i] = !m_q[k][i];
            endcase
          end
        end
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
        if (any_conf && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
`endif
      end
    end
  endtask

  task automatic step(input logic i_rst, input logic i_en, input logic [1:0] i_mode,
                      input logic [W-1:0] i_s, input logic [W-1:0] i_r, input logic i_clr);
    exp_t e;
    @(negedge clk);
    rst = i_rst; en = i_en; mode = i_mode; s = i_s; r = i_r; clr_conflict = i_clr;
    model_edge(i_rst, i_en, i_mode, i_s, i_r, i_clr);
    for (int k = 0; k < 3; k++) begin
      e.q[k] = m_q[k]; e.c[k] = m_c[k]; e.cnt[k] = m_cnt[k];
    end
    sb.push_back(e);
  endtask

  // Monitor: every edge is an output event; pop the expectation pushed for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q_p0", q0, e.q[0]);   check("qn_p0", qn0, ~e.q[0]);  check("conf_p0", c0, e.c[0]);
        check("q_p1", q1, e.q[1]);   check("qn_p1", qn1, ~e.q[1]);  check("conf_p1", c1, e.c[1]);
        check("q_p2", q2, e.q[2]);   check("qn_p2", qn2, ~e.q[2]);  check("conf_p2", c2, e.c[2]);
        check("cnt_p0", cnt0, W'(e.cnt[0]));
        check("cnt_p1", {6'b0, cnt1}, W'(e.cnt[1]));
        check("cnt_p2", cnt2, W'(e.cnt[2]));
      end
    end
  end

  initial begin
    logic [W-1:0] rs, rr, xr;
    rst = 1'b1; en = 1'b0; mode = 2'd0; s = '0; r = '0; clr_conflict = 1'b0;
    xr = 'x;
    // Reset and SR basics
    step(1, 0, 2'd0, 8'h00, 8'h00, 0);
    step(1, 1, 2'd3, 8'hFF, 8'hFF, 1);
    step(0, 1, 2'd0, 8'h0F, 8'hF0, 0);
    // Conflict policy from q=00, then sticky check
    step(0, 1, 2'd0, 8'h00, 8'hFF, 0);
    step(0, 1, 2'd0, 8'h81, 8'h81, 0);
    step(0, 1, 2'd0, 8'h00, 8'h00, 0);
    // JK toggle and enable gating
    step(0, 1, 2'd2, 8'h3C, xr, 0);
    step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
    step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 8'hFF, 8'hFF, 0);
    // D and T modes, r unknown where ignored
    step(0, 1, 2'd2, 8'h5A, xr, 0);
    step(0, 1, 2'd3, 8'h0F, xr, 0);
    step(0, 1, 2'd3, 8'h0F, xr, 0);
    // Clear versus new conflict on the same edge, and clear while disabled
    step(0, 1, 2'd0, 8'h02, 8'h02, 1);
    step(0, 0, 2'd0, 8'h00, 8'h00, 1);
    // Saturation of the 2-bit counter, then reset mid T sequence
    for (int i = 0; i < 5; i++) step(0, 1, 2'd0, 8'h10, 8'h10, 0);
    step(0, 1, 2'd3, 8'hF0, 8'h00, 0);
    step(1, 1, 2'd3, 8'hF0, 8'h00, 0);
    step(0, 1, 2'd3, 8'h33, 8'h00, 0);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rs = W'($urandom);
      rr = W'($urandom);
      if ($urandom_range(0, 2) == 0) rr = rr | rs;
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
           rs, rr, ($urandom_range(0, 9) == 0));
    end
    step(0, 0, 2'd0, 8'h00, 8'h00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised successor to the single-bit SR flip-flop: a WIDTH-bit bank of per-bit storage elements, each updated on the rising edge of clk.
- A runtime mode input selects SR, JK, D or T behaviour.
- The s=r=1 SR case is resolved by a parameter-selected policy; every occurrence is also flagged in a sticky per-bit conflict register.
- Used as a generic control/status flop bank in datapaths and as the common stimulus target for flip-flop benches.

Parameters:
- WIDTH, 8: number of bits in the bank (1..64).
- RESET_VAL, 0 (WIDTH bits): value loaded into q on reset.
- SR_CONFLICT, 0: SR-mode policy for s=r=1. 0 = hold, 1 = set wins, 2 = reset wins. Any other value behaves as 0.
- CNT_W, 8: width of the conflict event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable; 0 = all q bits hold.
- mode  input  2  00 = SR, 01 = JK, 10 = D, 11 = T.
- s  input  WIDTH  per-bit S / J / D / T input.
- r  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- clr_conflict  input  1  single-cycle clear of conflict and conflict_cnt.
- q  output  WIDTH  registered state.
- q_  output  WIDTH  always equal to ~q (combinational inversion of the register, never separately stored).
- conflict  output  WIDTH  sticky per-bit flag: s=r=1 was seen in SR mode.
- conflict_cnt  output  CNT_W  conflict event count; tied 0 when the optional feature is off.

Behaviour:
- All state updates on posedge clk. Latency from input to q is one cycle.
- Priority per cycle: rst > en.
- Reset: at an edge with rst=1, q <= RESET_VAL, q_ = ~RESET_VAL, conflict <= 0, conflict_cnt <= 0.
  - Reset overrides en, mode, s, r and clr_conflict.
  - A reset asserted mid-sequence discards all pending state.
- en=0: q and conflict hold. clr_conflict is still honoured.
- Per-bit next state when en=1:
  - SR mode:
    - s=0,r=0: hold.
    - s=1,r=0: q=1.
    - s=0,r=1: q=0.
    - s=1,r=1: resolved per SR_CONFLICT.
  - JK mode:
    - j=0,k=0: hold.
    - j=1,k=0: q=1.
    - j=0,k=1: q=0.
    - j=1,k=1: toggle.
  - D mode: q=s.
  - T mode: q=q^s.
- Mode changes take effect on the same edge at which they are sampled. There is no pipeline and no history.
- Conflict detection:
  - Only when en=1 and mode=SR: conflict[i] <= 1 for every bit with s[i]&r[i].
  - JK, D and T modes never set conflict.
- clr_conflict=1 clears all conflict bits. If a new conflict occurs on the same edge, the new conflict bits end up set; the new event wins over the clear.
- Bits are fully independent. Simultaneous set, reset and conflict on different bits is legal and resolved per bit.
- No X propagation is tolerated: an X on s or r in a don't-care mode (r in D/T) must not affect q.

Optional Feature:
- Macro: SR_FF_BANK_CONFLICT_CNT_EN.
- Defined:
  - conflict_cnt increments by 1 on each enabled SR-mode cycle in which at least one bit has s=r=1. The count is per cycle, not per bit.
  - It saturates at all-ones.
  - clr_conflict resets it to 0. If clr_conflict and a new conflict land on the same edge, it loads 1.
- Undefined:
  - conflict_cnt is driven constant 0 and no counter flops are synthesised.
  - The port list is unchanged.

Test Plan:
- Reset and SR basics. WIDTH=8, RESET_VAL=8'hA5; hold rst=1 for 2 edges -> q=A5, q_=5A, conflict=0. Release rst, mode=SR, s=8'h0F, r=8'hF0 for one edge -> q=0F, q_=F0.
- Conflict policy. SR mode, q=00, s=r=8'h81 for one edge:
  - SR_CONFLICT=0 -> q=00.
  - SR_CONFLICT=1 -> q=81.
  - SR_CONFLICT=2 -> q=00.
  - All three -> conflict=81.
  - Then s=r=0 for one edge -> conflict stays 81.
- JK toggle and enable gating. mode=JK, q=3C, s=r=FF -> q=C3, then next edge q=3C. Set en=0 with s=r=FF for 3 edges -> q stays 3C, conflict unchanged.
- D and T modes. mode=D, s=5A, r=XX -> q=5A. mode=T, s=0F -> q=55, next edge q=5A.
- Clear versus new conflict. conflict=81; clr_conflict=1 with s=r=8'h02 in SR mode on the same edge -> conflict=02. With the macro defined, conflict_cnt=1. With the macro undefined, conflict_cnt=0.
- Counter saturation and reset mid-operation. Macro defined, CNT_W=2; 5 consecutive conflict cycles -> conflict_cnt=3 (held). Assert rst for 1 edge during an active T-mode sequence -> q=RESET_VAL, conflict=0, conflict_cnt=0.
